encoder_emulator: RTL and testbench

- Quadrature encoder signal generator: synthesises A/B/Z outputs from a commanded step period and direction.
- Output edges follow the same Gray sequence and index convention that the AMDC quadrature decoder counts, so the emulator can drive that decoder in loopback. It can also drive an external drive under test as a simulated motor shaft.
- Sits beside the decoder in the encoder IP. All control inputs come from AXI-written registers in the wrapper.

---
 rtl/encoder_emulator.sv | 131 +++++++++++++
 tb/tb_encoder_emulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: turns a commanded edge period and direction into
// A/B/Z using the same Gray order and index convention the quadrature decoder counts.
module encoder_emulator #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         dir,
    input  logic [W-1:0] period,
    input  logic [W-1:0] pulses_per_rev,
    input  logic         pos_load,
    input  logic [W-1:0] pos_load_val,
    output logic         A,
    output logic         B,
    output logic         Z,
    output logic [W-1:0] position,
    output logic [W-1:0] step_count,
    output logic         step_pulse
);

    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_10 = 2'b10,
        AB_11 = 2'b11,
        AB_01 = 2'b01
    } ab_state_t;

    localparam logic [W-1:0]        ONE_U = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] ONE_S = {{(W-1){1'b0}}, 1'b1};

    ab_state_t           ab_q, ab_d;
    logic [W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]        pos_q, pos_d;
    logic signed [W-1:0] steps_q, steps_d;
    logic                z_q, z_d;
    logic                pulse_q, pulse_d;

    logic                run;
    logic                step;
    logic [W-1:0]        period_m1;

    // Wrap rules tolerate an out-of-range position left by an unchecked load.
    function automatic logic [W-1:0] pos_next(input logic [W-1:0] pos,
                                              input logic [W-1:0] ppr,
                                              input logic         fwd);
        logic [W-1:0] res;
        if (ppr <= ONE_U) begin
            res = '0;
        end else if (fwd) begin
            res = (pos >= ppr - ONE_U) ? '0 : pos + ONE_U;
        end else begin
            res = ((pos == '0) || (pos >= ppr)) ? ppr - ONE_U : pos - ONE_U;
        end
        return res;
    endfunction

    // Net edge counter; wraps modulo 2^W by construction.
    function automatic logic signed [W-1:0] steps_next(input logic signed [W-1:0] s,
                                                       input logic                fwd);
        return fwd ? s + ONE_S : s - ONE_S;
    endfunction

    assign run       = enable && (period != '0);
    assign period_m1 = period - ONE_U;
    // >= rather than == so a shortened period fires immediately instead of wrapping.
    assign step      = run && (cnt_q >= period_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE_U;
        end
    end

    always_comb begin
        ab_d = ab_q;
        if (step) begin
            unique case (ab_q)
                AB_00:   ab_d = dir ? AB_10 : AB_01;
                AB_10:   ab_d = dir ? AB_11 : AB_00;
                AB_11:   ab_d = dir ? AB_01 : AB_10;
                AB_01:   ab_d = dir ? AB_00 : AB_11;
                default: ab_d = AB_00;
            endcase
        end
    end

    always_comb begin
        pos_d   = pos_q;
        steps_d = steps_q;
        pulse_d = step;
        if (step) begin
            pos_d   = pos_next(pos_q, pulses_per_rev, dir);
            steps_d = steps_next(steps_q, dir);
        end
        if (pos_load) begin
            pos_d = pos_load_val;
        end
        // Registered from next position so Z moves on the same edge as A/B.
        z_d = enable && (pos_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q    <= AB_00;
            cnt_q   <= '0;
            pos_q   <= '0;
            steps_q <= '0;
            z_q     <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            ab_q    <= ab_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            steps_q <= steps_d;
            z_q     <= z_d;
            pulse_q <= pulse_d;
        end
    end

    assign A          = ab_q[1];
    assign B          = ab_q[0];
    assign Z          = z_q;
    assign position   = pos_q;
    assign step_count = steps_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_encoder_emulator.sv
// Scoreboard bench for encoder_emulator: expected edges are queued as stimulus is
// driven and matched on step_pulse; a bench-side quadrature decoder checks loopback.
module tb_encoder_emulator;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        dir;
    logic [31:0] period;
    logic [31:0] ppr;
    logic        pos_load;
    logic [31:0] pos_load_val;
    logic        A, B, Z;
    logic [31:0] position;
    logic [31:0] step_count;
    logic        step_pulse;

    encoder_emulator #(.W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .dir            (dir),
        .period         (period),
        .pulses_per_rev (ppr),
        .pos_load       (pos_load),
        .pos_load_val   (pos_load_val),
        .A              (A),
        .B              (B),
        .Z              (Z),
        .position       (position),
        .step_count     (step_count),
        .step_pulse     (step_pulse)
    );

    typedef struct {
        logic [1:0]  ab;
        logic [31:0] pos;
        logic [31:0] cnt;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        sb_en;
    logic [31:0] m_pos, m_cnt, m_ppr;
    int          dec_cnt, dec_pos;
    logic [1:0]  gray_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int ab_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic fwd);
        if (m_ppr <= 1) return 32'd0;
        if (fwd) return (p >= m_ppr - 1) ? 32'd0 : p + 1;
        return ((p == 0) || (p >= m_ppr)) ? m_ppr - 1 : p - 1;
    endfunction

    task automatic push_step(input logic fwd, input logic ld, input logic [31:0] ldv, input int c);
        m_cnt = fwd ? m_cnt + 1 : m_cnt - 1;
        m_pos = ld ? ldv : model_next(m_pos, fwd);
        sb.push_back('{ab: gray_seq[m_cnt[1:0]], pos: m_pos, cnt: m_cnt, z: (m_pos == 0), cyc: c});
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_cnt = 0;
    endtask

    // Run n steps from a stopped divider, then stop again.
    task automatic run_steps(input logic fwd, input int p, input int n);
        int k;
        dir    = fwd;
        period = p;
        k      = cyc;
        enable = 1'b1;
        for (int i = 1; i <= n; i++) push_step(fwd, 1'b0, 32'd0, k + p * i);
        wait_until(k + p * n + 1);
        enable = 1'b0;
        tick();
        check("run_drain", sb.size(), 0);
    endtask

    task automatic monitor();
        exp_t       e;
        logic [1:0] ab;
        logic [1:0] ab_prev;
        int         d;
        ab_prev = 2'b00;
        forever begin
            @(negedge clk);
            ab = {A, B};
            if (!rst_n) begin
                ab_prev = 2'b00;
                dec_cnt = 0;
                dec_pos = 0;
            end else begin
                if (ab != ab_prev) begin
                    check("ab_one_toggle", $countones(ab ^ ab_prev), 1);
                    check("ab_with_pulse", step_pulse, 1);
                    d = (ab_idx(ab) - ab_idx(ab_prev)) & 3;
                    if (d == 1) begin
                        dec_cnt++;
                        dec_pos = (dec_pos >= int'(ppr) - 1) ? 0 : dec_pos + 1;
                    end else if (d == 3) begin
                        dec_cnt--;
                        dec_pos = (dec_pos == 0) ? int'(ppr) - 1 : dec_pos - 1;
                    end
                    ab_prev = ab;
                end
                if (sb_en && step_pulse) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_step", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("step_cyc", cyc, e.cyc);
                        check("step_ab", ab, e.ab);
                        check("step_pos", position, e.pos);
                        check("step_count", step_count, e.cnt);
                        check("step_z", Z, e.z);
                    end
                end
            end
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; enable = 1'b0; dir = 1'b1; period = 0; ppr = 8;
        pos_load = 1'b0; pos_load_val = 0; sb_en = 1'b1;
        m_ppr = 8;
        model_reset();
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("rst_ab", {A, B}, 2'b00);
        check("rst_z", Z, 0);
        check("rst_pos", position, 0);
        check("rst_cnt", step_count, 0);
        check("rst_pulse", step_pulse, 0);
        rst_n = 1'b1;
        tick();

        // forward run, then drop enable while at position 0
        dir = 1'b1; period = 4; k = cyc; enable = 1'b1;
        for (int i = 1; i <= 8; i++) push_step(1'b1, 1'b0, 32'd0, k + 4 * i);
        tick();
        check("fwd_z_start", Z, 1);
        wait_until(k + 33);
        check("fwd_drain", sb.size(), 0);
        check("fwd_count", step_count, 8);
        check("fwd_z_end", Z, 1);
        enable = 1'b0;
        tick();
        check("dis_z", Z, 0);
        check("dis_ab", {A, B}, 2'b00);
        check("dis_pos", position, 0);
        repeat (10) tick();
        check("dis_hold_ab", {A, B}, 2'b00);
        check("dis_hold_cnt", step_count, 8);

        // asynchronous reset mid-run
        dir = 1'b1; period = 3; k = cyc; enable = 1'b1;
        for (int i = 1; i <= 3; i++) push_step(1'b1, 1'b0, 32'd0, k + 3 * i);
        wait_until(k + 10);
        check("mid_drain", sb.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ab", {A, B}, 2'b00);
        check("arst_z", Z, 0);
        check("arst_pos", position, 0);
        check("arst_cnt", step_count, 0);
        check("arst_pulse", step_pulse, 0);
        model_reset();
        tick();
        tick();
        period = 5; dir = 1'b1; rst_n = 1'b1; k = cyc;
        push_step(1'b1, 1'b0, 32'd0, k + 5);
        tick();
        check("rel_z", Z, 1);
        wait_until(k + 6);
        check("rel_ab", {A, B}, 2'b10);
        enable = 1'b0;
        tick();
        check("rel_drain", sb.size(), 0);

        // reverse wrap from reset
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1; dir = 1'b0; period = 2; k = cyc; enable = 1'b1;
        for (int i = 1; i <= 3; i++) push_step(1'b0, 1'b0, 32'd0, k + 2 * i);
        tick();
        check("rev_z_start", Z, 1);
        wait_until(k + 7);
        enable = 1'b0;
        tick();
        check("rev_drain", sb.size(), 0);

        // period shrink below the running count, then stop with period 0
        dir = 1'b1; period = 100; k = cyc; enable = 1'b1;
        wait_until(k + 50);
        period = 3;
        for (int i = 0; i < 3; i++) push_step(1'b1, 1'b0, 32'd0, k + 51 + 3 * i);
        wait_until(k + 58);
        period = 0;
        wait_until(k + 80);
        check("shrink_drain", sb.size(), 0);
        check("stop_hold_pos", position, m_pos);
        check("stop_hold_cnt", step_count, m_cnt);
        check("stop_hold_ab", {A, B}, gray_seq[m_cnt[1:0]]);
        enable = 1'b0;
        tick();

        // pos_load coincident with a step, then an out-of-range load
        dir = 1'b1; period = 4; k = cyc; enable = 1'b1;
        push_step(1'b1, 1'b0, 32'd0, k + 4);
        push_step(1'b1, 1'b1, 32'd5, k + 8);
        push_step(1'b1, 1'b0, 32'd0, k + 12);
        wait_until(k + 7);
        pos_load = 1'b1; pos_load_val = 5;
        tick();
        pos_load = 1'b0;
        wait_until(k + 13);
        pos_load = 1'b1; pos_load_val = 12;
        tick();
        pos_load = 1'b0;
        check("load_oor_pos", position, 12);
        check("load_oor_z", Z, 0);
        m_pos = 12;
        push_step(1'b1, 1'b0, 32'd0, k + 16);
        push_step(1'b1, 1'b0, 32'd0, k + 20);
        wait_until(k + 21);
        enable = 1'b0;
        tick();
        check("load_drain", sb.size(), 0);

        // degenerate revolution sizes pin position to 0
        ppr = 1; m_ppr = 1;
        run_steps(1'b1, 2, 2);
        ppr = 0; m_ppr = 0;
        run_steps(1'b0, 2, 1);

        // loopback against the bench decoder
        sb_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1; ppr = 4096; m_ppr = 4096; dir = 1'b1; period = 2;
        k = cyc; enable = 1'b1;
        wait_until(k + 20000);
        enable = 1'b0;
        tick();
        check("loop_fwd_dec_cnt", dec_cnt, 10000);
        check("loop_fwd_dec_pos", dec_pos, 1808);
        check("loop_fwd_pos", position, 1808);
        check("loop_fwd_count", step_count, 10000);
        dir = 1'b0; k = cyc; enable = 1'b1;
        wait_until(k + 20000);
        enable = 1'b0;
        tick();
        check("loop_rev_dec_cnt", dec_cnt, 0);
        check("loop_rev_dec_pos", dec_pos, 0);
        check("loop_rev_pos", position, 0);
        check("loop_rev_count", step_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
